// File: rtl/gobou_mac_ctrl.sv
// gobou_mac_ctrl
//   Sequencer for one gobou MAC lane running a fully-connected layer.
//   For each of M output neurons it clears the MAC and streams N input/weight
//   address pairs to 1-cycle synchronous RAMs. It raises mac_accum_we MAC_LAT
//   cycles after each address issue, so the enable lines up with the MAC operand
//   register. It then latches the MAC result and writes it to the output RAM.
//
// Ports
//   clk, xrst              clock, synchronous active-low reset
//   req                    layer start, sampled only while idle
//   in_size / out_size     N inputs per neuron / M neurons, sampled with req
//   in_base/w_base/out_base RAM base addresses, sampled with req
//   busy, ack              busy outside IDLE; ack pulses once per finished layer
//   in_addr, w_addr        input / weight RAM read addresses
//   mac_reset, mac_accum_we, mac_out_en  MAC clear / accumulate / result latch
//   out_we, out_addr       output RAM write (data comes from the MAC)
//
// Addresses are registers: they hold their last value outside ISSUE/WB and
// only the enables are qualified by state.

module gobou_mac_ctrl #(
    parameter int LWIDTH  = 10,
    parameter int AWIDTH  = 16,
    parameter int MAC_LAT = 2
) (
    input  logic              clk,
    input  logic              xrst,
    input  logic              req,
    input  logic [LWIDTH-1:0] in_size,
    input  logic [LWIDTH-1:0] out_size,
    input  logic [AWIDTH-1:0] in_base,
    input  logic [AWIDTH-1:0] w_base,
    input  logic [AWIDTH-1:0] out_base,
    output logic              busy,
    output logic              ack,
    output logic [AWIDTH-1:0] in_addr,
    output logic [AWIDTH-1:0] w_addr,
    output logic              mac_reset,
    output logic              mac_accum_we,
    output logic              mac_out_en,
    output logic              out_we,
    output logic [AWIDTH-1:0] out_addr
);

    localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        ISSUE,
        DRAIN,
        OUT,
        WB,
        DONE
    } state_t;

    state_t              state, next;

    // Layer parameters captured at start; the live inputs are ignored while busy.
    logic [LWIDTH-1:0]   n_r, m_r;
    logic [AWIDTH-1:0]   in_base_r, out_base_r;

    logic [LWIDTH-1:0]   i_cnt, j_cnt;
    logic [DW-1:0]       d_cnt;

    // Weight address of the next neuron's first operand. It advances by N per
    // neuron through the running w_addr, so no j*N multiply is needed.
    logic [AWIDTH-1:0]   w_ptr;

    // One bit per ISSUE cycle, delayed MAC_LAT cycles to reach the MAC
    // operand register stage.
    logic [MAC_LAT-1:0]  acc_pipe;
    logic                push;

    logic                i_last, j_last, start, size_zero;

    assign i_last       = (i_cnt == n_r - 1'b1);
    assign j_last       = (j_cnt == m_r - 1'b1);
    assign size_zero    = (in_size == '0) || (out_size == '0);
    assign start        = (state == IDLE) && req && !size_zero;
    assign mac_accum_we = acc_pipe[MAC_LAT-1];

    always_ff @(posedge clk) begin
        if (!xrst) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next       = state;
        busy       = 1'b1;
        ack        = 1'b0;
        mac_reset  = 1'b0;
        mac_out_en = 1'b0;
        out_we     = 1'b0;
        push       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (req) next = size_zero ? DONE : CLR;
            end
            CLR: begin
                mac_reset = 1'b1;
                next      = ISSUE;
            end
            ISSUE: begin
                push = 1'b1;
                if (i_last) next = DRAIN;
            end
            DRAIN: begin
                if (d_cnt == DW'(MAC_LAT - 1)) next = OUT;
            end
            OUT: begin
                mac_out_en = 1'b1;
                next       = WB;
            end
            WB: begin
                out_we = 1'b1;
                next   = j_last ? DONE : CLR;
            end
            DONE: begin
                ack  = 1'b1;
                next = IDLE;
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!xrst) begin
            acc_pipe <= '0;
        end else begin
            acc_pipe[0] <= push;
            for (int k = 1; k < MAC_LAT; k++) acc_pipe[k] <= acc_pipe[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!xrst) begin
            n_r        <= '0;
            m_r        <= '0;
            in_base_r  <= '0;
            out_base_r <= '0;
            w_ptr      <= '0;
            i_cnt      <= '0;
            j_cnt      <= '0;
            d_cnt      <= '0;
            in_addr    <= '0;
            w_addr     <= '0;
            out_addr   <= '0;
        end else begin
            if (start) begin
                n_r        <= in_size;
                m_r        <= out_size;
                in_base_r  <= in_base;
                out_base_r <= out_base;
                w_ptr      <= w_base;
                i_cnt      <= '0;
                j_cnt      <= '0;
            end
            case (state)
                CLR: begin
                    // Addresses must be valid during the first ISSUE cycle.
                    in_addr <= in_base_r;
                    w_addr  <= w_ptr;
                    d_cnt   <= '0;
                end
                ISSUE: begin
                    if (i_last) begin
                        i_cnt <= '0;
                        w_ptr <= w_addr + 1'b1;
                    end else begin
                        i_cnt   <= i_cnt + 1'b1;
                        in_addr <= in_addr + 1'b1;
                        w_addr  <= w_addr + 1'b1;
                    end
                end
                DRAIN: d_cnt <= d_cnt + 1'b1;
                OUT:   out_addr <= out_base_r + AWIDTH'(j_cnt);
                WB: begin
                    if (!j_last) j_cnt <= j_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gobou_mac_ctrl.sv
// Bench for gobou_mac_ctrl: drives layers, runs a golden 1-cycle RAM + Q8.8 MAC
// around the sequencer, and compares an event trace against a cycle-formula model.
module tb_gobou_mac_ctrl;
    localparam int LW = 10, AW = 16, LAT = 2;

    logic          clk = 1'b0, xrst = 1'b0, req = 1'b0;
    logic [LW-1:0] in_size = '0, out_size = '0;
    logic [AW-1:0] in_base = '0, w_base = '0, out_base = '0;
    logic          busy, ack, mac_reset, mac_accum_we, mac_out_en, out_we;
    logic [AW-1:0] in_addr, w_addr, out_addr;

    always #5 clk = ~clk;

    gobou_mac_ctrl #(.LWIDTH(LW), .AWIDTH(AW), .MAC_LAT(LAT)) dut (
        .clk(clk), .xrst(xrst), .req(req), .in_size(in_size), .out_size(out_size),
        .in_base(in_base), .w_base(w_base), .out_base(out_base), .busy(busy), .ack(ack),
        .in_addr(in_addr), .w_addr(w_addr), .mac_reset(mac_reset),
        .mac_accum_we(mac_accum_we), .mac_out_en(mac_out_en), .out_we(out_we),
        .out_addr(out_addr)
    );

    // Golden RAMs and MAC (Q8.8 operands, product shifted back by 8).
    logic signed [15:0] in_ram [0:65535];
    logic signed [15:0] w_ram  [0:65535];
    logic signed [15:0] in_q, w_q, x_r, w_r, y;
    int                 acc;

    always @(posedge clk) begin
        in_q <= in_ram[in_addr];
        w_q  <= w_ram[w_addr];
        x_r  <= in_q;
        w_r  <= w_q;
        if (mac_reset) acc <= 0;
        else if (mac_accum_we) acc <= acc + ((int'(x_r) * int'(w_r)) >>> 8);
        if (mac_out_en) y <= acc[15:0];
    end

    int    cyc = 0;
    int    t0 = 0;
    int    n_pass = 0, n_chk = 0;
    string ctl_s, acc_s, owe_s, exp_ctl, exp_acc, exp_owe;
    int    busy_n, ovl_n, exp_busy;

    always @(posedge clk) cyc <= cyc + 1;

    // Trace monitor. Accumulate events record the addresses issued LAT cycles earlier.
    initial begin
        int rel, ia1, ia2, wa1, wa2;
        ia1 = 0; ia2 = 0; wa1 = 0; wa2 = 0;
        forever begin
            @(negedge clk);
            rel = cyc - t0;
            if (mac_reset)    ctl_s = {ctl_s, $sformatf("R%0d ", rel)};
            if (mac_out_en)   ctl_s = {ctl_s, $sformatf("O%0d ", rel)};
            if (ack)          ctl_s = {ctl_s, $sformatf("A%0d ", rel)};
            if (mac_accum_we) acc_s = {acc_s, $sformatf("%0d:%0d/%0d ", rel, ia2, wa2)};
            if (out_we)       owe_s = {owe_s, $sformatf("%0d:%0d=%0d ", rel, out_addr, y)};
            if (busy) busy_n++;
            if (int'(mac_reset) + int'(mac_accum_we) + int'(mac_out_en) + int'(out_we) > 1) ovl_n++;
            ia2 = ia1; ia1 = int'(in_addr);
            wa2 = wa1; wa1 = int'(w_addr);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run_cycles(input int k);
        repeat (k) tick();
    endtask

    task automatic clear_logs();
        ctl_s = ""; acc_s = ""; owe_s = ""; busy_n = 0; ovl_n = 0;
        exp_ctl = ""; exp_acc = ""; exp_owe = ""; exp_busy = 0;
    endtask

    task automatic fill(input int n, input int m, input int ib, input int wb);
        for (int i = 0; i < n; i++) in_ram[16'(ib + i)] = 16'($urandom_range(1023) - 512);
        for (int k = 0; k < n * m; k++) w_ram[16'(wb + k)] = 16'($urandom_range(1023) - 512);
    endtask

    // Expected trace from the layer timing rules: neuron j occupies cycles
    // off+j*P+1 .. off+(j+1)*P with P=N+LAT+3, then DONE at off+M*P+1.
    task automatic model_layer(input int n, input int m, input int ib, input int wb,
                               input int ob, input int off);
        int p;
        p = n + LAT + 3;
        if (n == 0 || m == 0) begin
            exp_ctl = {exp_ctl, $sformatf("A%0d ", off + 1)};
            exp_busy += 1;
            return;
        end
        for (int j = 0; j < m; j++) begin
            int base, sum, ia, wa;
            logic signed [15:0] ye;
            base = off + j * p;
            exp_ctl = {exp_ctl, $sformatf("R%0d O%0d ", base + 1, base + n + 4)};
            sum = 0;
            for (int i = 0; i < n; i++) begin
                ia = (ib + i) & 65535;
                wa = (wb + j * n + i) & 65535;
                exp_acc = {exp_acc, $sformatf("%0d:%0d/%0d ", base + 2 + i + LAT, ia, wa)};
                sum += (int'(in_ram[ia]) * int'(w_ram[wa])) >>> 8;
            end
            ye = 16'(sum);
            exp_owe = {exp_owe, $sformatf("%0d:%0d=%0d ", base + n + 5, (ob + j) & 65535, ye)};
        end
        exp_ctl = {exp_ctl, $sformatf("A%0d ", off + m * p + 1)};
        exp_busy += m * p + 1;
    endtask

    task automatic start_layer(input int n, input int m, input int ib, input int wb,
                               input int ob, input bit hold);
        in_size = LW'(n); out_size = LW'(m);
        in_base = AW'(ib); w_base = AW'(wb); out_base = AW'(ob);
        req = 1'b1;
        t0 = cyc;
        tick();
        if (!hold) req = 1'b0;
    endtask

    task automatic test_reset();
        xrst = 1'b0;
        req = 1'b1; in_size = 3; out_size = 2;
        run_cycles(3);
        n_chk++;
        if ({busy, ack, mac_reset, mac_accum_we, mac_out_en, out_we} !== 6'b0)
            $display("FAIL reset_ctl: got %b want 000000",
                     {busy, ack, mac_reset, mac_accum_we, mac_out_en, out_we});
        else n_pass++;
        n_chk++;
        if (in_addr !== 16'h0) $display("FAIL reset_in_addr: got %0h want 0", in_addr); else n_pass++;
        n_chk++;
        if (w_addr !== 16'h0) $display("FAIL reset_w_addr: got %0h want 0", w_addr); else n_pass++;
        n_chk++;
        if (out_addr !== 16'h0) $display("FAIL reset_out_addr: got %0h want 0", out_addr); else n_pass++;
        req = 1'b0;
        xrst = 1'b1;
        run_cycles(2);
        n_chk++;
        if (busy !== 1'b0) $display("FAIL reset_idle_busy: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_spec_example();
        for (int i = 0; i < 3; i++) in_ram[i] = 16'sd256;
        for (int i = 100; i < 106; i++) w_ram[i] = 16'sd128;
        clear_logs();
        start_layer(3, 2, 0, 100, 200, 1'b0);
        run_cycles(20);
        n_chk++;
        if (ctl_s != "R1 O7 R9 O15 A17 ")
            $display("FAIL ex_ctl: got '%s' want 'R1 O7 R9 O15 A17 '", ctl_s);
        else n_pass++;
        n_chk++;
        if (acc_s != "4:0/100 5:1/101 6:2/102 12:0/103 13:1/104 14:2/105 ")
            $display("FAIL ex_accum: got '%s'", acc_s);
        else n_pass++;
        n_chk++;
        if (owe_s != "8:200=384 16:201=384 ")
            $display("FAIL ex_out_we: got '%s' want '8:200=384 16:201=384 '", owe_s);
        else n_pass++;
        n_chk++;
        if (busy_n != 17) $display("FAIL ex_busy: got %0d want 17", busy_n); else n_pass++;
        n_chk++;
        if (ovl_n != 0) $display("FAIL ex_overlap: got %0d want 0", ovl_n); else n_pass++;
    endtask

    task automatic test_random();
        for (int k = 0; k < 5; k++) begin
            int n, m, ib, wb, ob;
            n = $urandom_range(1, 4); m = $urandom_range(1, 3);
            ib = $urandom_range(65535); wb = $urandom_range(65535); ob = $urandom_range(65535);
            fill(n, m, ib, wb);
            clear_logs();
            model_layer(n, m, ib, wb, ob, 0);
            start_layer(n, m, ib, wb, ob, 1'b0);
            run_cycles(m * (n + LAT + 3) + 4);
            n_chk++;
            if (ctl_s != exp_ctl) $display("FAIL rnd_ctl: got '%s' want '%s'", ctl_s, exp_ctl); else n_pass++;
            n_chk++;
            if (acc_s != exp_acc) $display("FAIL rnd_accum: got '%s' want '%s'", acc_s, exp_acc); else n_pass++;
            n_chk++;
            if (owe_s != exp_owe) $display("FAIL rnd_out_we: got '%s' want '%s'", owe_s, exp_owe); else n_pass++;
            n_chk++;
            if (busy_n != exp_busy) $display("FAIL rnd_busy: got %0d want %0d", busy_n, exp_busy); else n_pass++;
            n_chk++;
            if (ovl_n != 0) $display("FAIL rnd_overlap: got %0d want 0", ovl_n); else n_pass++;
        end
    endtask

    task automatic test_zero_size();
        for (int k = 0; k < 2; k++) begin
            clear_logs();
            model_layer(k * 3, (1 - k) * 3, 10, 20, 30, 0);
            start_layer(k * 3, (1 - k) * 3, 10, 20, 30, 1'b0);
            run_cycles(6);
            n_chk++;
            if (ctl_s != "A1 ") $display("FAIL zero_ctl: got '%s' want 'A1 '", ctl_s); else n_pass++;
            n_chk++;
            if (acc_s != "" || owe_s != "")
                $display("FAIL zero_activity: got '%s%s' want ''", acc_s, owe_s);
            else n_pass++;
            n_chk++;
            if (busy_n != exp_busy) $display("FAIL zero_busy: got %0d want %0d", busy_n, exp_busy); else n_pass++;
        end
    endtask

    task automatic test_wrap();
        fill(4, 1, 65533, 65534);
        clear_logs();
        model_layer(4, 1, 65533, 65534, 65535, 0);
        start_layer(4, 1, 65533, 65534, 65535, 1'b0);
        run_cycles(14);
        n_chk++;
        if (acc_s != "4:65533/65534 5:65534/65535 6:65535/0 7:0/1 ")
            $display("FAIL wrap_accum: got '%s'", acc_s);
        else n_pass++;
        n_chk++;
        if (owe_s != exp_owe) $display("FAIL wrap_out_we: got '%s' want '%s'", owe_s, exp_owe); else n_pass++;
        n_chk++;
        if (ctl_s != exp_ctl) $display("FAIL wrap_ctl: got '%s' want '%s'", ctl_s, exp_ctl); else n_pass++;
    endtask

    task automatic test_abort();
        fill(4, 3, 40, 500);
        clear_logs();
        start_layer(4, 3, 40, 500, 900, 1'b0);
        run_cycles(11);            // now in neuron 1 ISSUE
        xrst = 1'b0;
        tick();
        n_chk++;
        if ({busy, ack, mac_reset, mac_accum_we, mac_out_en, out_we, in_addr, w_addr, out_addr} !== '0)
            $display("FAIL abort_outputs: got busy=%b accum=%b in=%0d w=%0d out=%0d want all 0",
                     busy, mac_accum_we, in_addr, w_addr, out_addr);
        else n_pass++;
        xrst = 1'b1;
        clear_logs();
        run_cycles(30);
        n_chk++;
        if (ctl_s != "" || acc_s != "" || owe_s != "")
            $display("FAIL abort_quiet: got '%s|%s|%s' want ''", ctl_s, acc_s, owe_s);
        else n_pass++;
        clear_logs();
        model_layer(4, 3, 40, 500, 900, 0);
        start_layer(4, 3, 40, 500, 900, 1'b0);
        run_cycles(32);
        n_chk++;
        if (ctl_s != exp_ctl) $display("FAIL abort_rerun_ctl: got '%s' want '%s'", ctl_s, exp_ctl); else n_pass++;
        n_chk++;
        if (owe_s != exp_owe) $display("FAIL abort_rerun_out: got '%s' want '%s'", owe_s, exp_owe); else n_pass++;
        n_chk++;
        if (acc_s != exp_acc) $display("FAIL abort_rerun_accum: got '%s' want '%s'", acc_s, exp_acc); else n_pass++;
    endtask

    task automatic test_back_to_back();
        fill(2, 2, 7, 3000);
        clear_logs();
        // Layer 1 ends at 15; IDLE at 16 samples the held req.
        model_layer(2, 2, 7, 3000, 60, 0);
        model_layer(2, 2, 7, 3000, 60, 16);
        start_layer(2, 2, 7, 3000, 60, 1'b1);
        run_cycles(16);
        req = 1'b0;
        run_cycles(20);
        n_chk++;
        if (ctl_s != exp_ctl) $display("FAIL b2b_ctl: got '%s' want '%s'", ctl_s, exp_ctl); else n_pass++;
        n_chk++;
        if (owe_s != exp_owe) $display("FAIL b2b_out_we: got '%s' want '%s'", owe_s, exp_owe); else n_pass++;
        n_chk++;
        if (busy_n != exp_busy) $display("FAIL b2b_busy: got %0d want %0d", busy_n, exp_busy); else n_pass++;
    endtask

    task automatic test_req_while_busy();
        fill(3, 2, 1200, 2400);
        clear_logs();
        model_layer(3, 2, 1200, 2400, 4000, 0);
        start_layer(3, 2, 1200, 2400, 4000, 1'b0);
        run_cycles(5);
        in_size = 7; out_size = 5; in_base = 9; w_base = 99; out_base = 999;
        req = 1'b1;
        run_cycles(2);
        req = 1'b0;
        run_cycles(20);
        n_chk++;
        if (ctl_s != exp_ctl) $display("FAIL busyreq_ctl: got '%s' want '%s'", ctl_s, exp_ctl); else n_pass++;
        n_chk++;
        if (acc_s != exp_acc) $display("FAIL busyreq_accum: got '%s' want '%s'", acc_s, exp_acc); else n_pass++;
        n_chk++;
        if (owe_s != exp_owe) $display("FAIL busyreq_out_we: got '%s' want '%s'", owe_s, exp_owe); else n_pass++;
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) begin
            in_ram[a] = 16'h0;
            w_ram[a]  = 16'h0;
        end
        clear_logs();
        test_reset();
        test_spec_example();
        test_random();
        test_zero_size();
        test_wrap();
        test_abort();
        test_back_to_back();
        test_req_while_busy();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
